// File: rtl/dsi_lane_pkg.sv
// dsi_lane_pkg: FSM states, SOT byte, LP line codes and counter width shared by the lane controller
package dsi_lane_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LP01, S_LP00, S_ZERO, S_SOT, S_HS, S_EOT, S_EXIT} lane_state_t;
  localparam int CNT_W = 8;
  localparam logic [7:0] SOT_BYTE = 8'hB8;
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
endpackage

// File: rtl/lane_trail_gen.sv
// lane_trail_gen: one lane's last-bit tracker and SOT/data/trail/zero mux (in: byte_clk, byte_rst, state, ev, word, data; out: ser_data, ser_enable)
module lane_trail_gen
  import dsi_lane_pkg::*;
(
  input  logic        byte_clk,
  input  logic        byte_rst,
  input  lane_state_t state,
  input  logic        ev,
  input  logic        word,
  input  logic [7:0]  data,
  output logic [7:0]  ser_data,
  output logic        ser_enable
);
  logic last_bit, hs, trail;
  always_ff @(posedge byte_clk)
    if (byte_rst) last_bit <= 1'b0;
    else if (hs && ev) last_bit <= data[7];
  always_comb begin
    hs = state == S_HS;
    trail = state == S_EOT || (hs && word && !ev);
    ser_data = state == S_SOT ? SOT_BYTE : (hs && ev) ? data : trail ? {8{~last_bit}} : 8'h00;
    ser_enable = state == S_SOT || state == S_EOT || (hs && word);
  end
endmodule

// File: rtl/multi_lane_ctrl.sv
// multi_lane_ctrl: shared LP/HS FSM for 1..4 D-PHY data lanes (in: byte_clk, byte_rst, data, valid, hs_req; out: ack, hs_rdy, lane_idle, lp_p, lp_n, ser_data, ser_enable, ser_hi_z)
module multi_lane_ctrl
  import dsi_lane_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int T_LPX   = 1,
  parameter int T_PREP  = 1,
  parameter int T_ZERO  = 8,
  parameter int T_TRAIL = 8,
  parameter int T_EXIT  = 4
) (
  input  logic               byte_clk,
  input  logic               byte_rst,
  input  logic [8*LANES-1:0] data,
  input  logic [LANES-1:0]   valid,
  output logic               ack,
  input  logic               hs_req,
  output logic               hs_rdy,
  output logic               lane_idle,
  output logic [LANES-1:0]   lp_p,
  output logic [LANES-1:0]   lp_n,
  output logic [8*LANES-1:0] ser_data,
  output logic [LANES-1:0]   ser_enable,
  output logic               ser_hi_z
);
  lane_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [LANES-1:0] ev;
  logic [1:0] lp;
  logic run, done, partial;
  always_comb begin
    run = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      run = run & valid[k];
      ev[k] = run;
    end
    done = cnt == '0;
    partial = ev[0] && !(&ev);
    ack = state == S_HS && ev[0];
    hs_rdy = state == S_HS;
    lane_idle = state == S_IDLE;
    ser_hi_z = state inside {S_IDLE, S_LP01, S_LP00, S_EXIT};
    lp = (state == S_IDLE || state == S_EXIT) ? LP11 : state == S_LP01 ? LP01 : LP00;
    lp_p = {LANES{lp[1]}};
    lp_n = {LANES{lp[0]}};
  end
  always_ff @(posedge byte_clk)
    if (byte_rst) begin
      state <= S_IDLE;
      cnt <= '0;
    end else
      case (state)
        S_IDLE: if (hs_req) begin state <= S_LP01; cnt <= CNT_W'(T_LPX - 1); end
        S_LP01: if (done) begin state <= S_LP00; cnt <= CNT_W'(T_PREP - 1); end else cnt <= cnt - 1'b1;
        S_LP00: if (done) begin state <= S_ZERO; cnt <= CNT_W'(T_ZERO - 1); end else cnt <= cnt - 1'b1;
        S_ZERO: if (done) state <= S_SOT; else cnt <= cnt - 1'b1;
        S_SOT:  state <= S_HS;
        S_HS:   if (!hs_req || partial) begin state <= S_EOT; cnt <= CNT_W'(T_TRAIL - 1); end
        S_EOT:  if (done) begin state <= S_EXIT; cnt <= CNT_W'(T_EXIT - 1); end else cnt <= cnt - 1'b1;
        S_EXIT: if (done) state <= S_IDLE; else cnt <= cnt - 1'b1;
      endcase
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_trail_gen u_lane (
      .byte_clk   (byte_clk),
      .byte_rst   (byte_rst),
      .state      (state),
      .ev         (ev[i]),
      .word       (ev[0]),
      .data       (data[8*i+:8]),
      .ser_data   (ser_data[8*i+:8]),
      .ser_enable (ser_enable[i])
    );
  end
endmodule
